// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Brief    : Pipeline hazard controller for the 5-stage core. Multi-cycle
//            load-use stall, taken-branch flush/redirect with stall abort,
//            EX-stage operand forwarding with XZR exclusion, and saturating
//            stall / hazard performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int PC_W         = 32,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_STAGES = 2,
  parameter int ZERO_REG     = 31,
  parameter int CNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [REG_ADDR_W-1:0] rn_id,
  input  logic [REG_ADDR_W-1:0] rm_id,
  input  logic                  rn_vld_id,
  input  logic                  rm_vld_id,
  input  logic [REG_ADDR_W-1:0] rn_ex,
  input  logic [REG_ADDR_W-1:0] rm_ex,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  regwrite_ex,
  input  logic                  memread_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  regwrite_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  regwrite_wb,
  input  logic                  br_taken_mem,
  input  logic [PC_W-1:0]       br_target_mem,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_exmem,
  output logic                  pc_redirect,
  output logic [PC_W-1:0]       pc_redirect_addr,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      hazard_cnt
);

  localparam logic [REG_ADDR_W-1:0] c_ZERO     = REG_ADDR_W'(ZERO_REG);
  localparam logic [2:0]            c_REM_INIT = 3'(LOAD_LAT - 1);
  localparam logic                  c_FL_IDEX  = (FLUSH_STAGES >= 2);
  localparam logic                  c_FL_EXMEM = (FLUSH_STAGES >= 3);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_remaining;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_hazard_cnt;

  logic w_hz;
  logic w_stall;
  logic w_new_hz;

  // Load-use hazard: a load in EX writes a register the ID instruction reads
  assign w_hz = memread_ex & regwrite_ex & (rd_ex != c_ZERO) &
                ((rn_vld_id & (rn_id == rd_ex)) | (rm_vld_id & (rm_id == rd_ex)));

  // Pipeline control: branch redirect wins over any stall request
  always_comb begin
    pc_write         = 1'b1;
    ifid_write       = 1'b1;
    idex_bubble      = 1'b0;
    flush_ifid       = 1'b0;
    flush_idex       = 1'b0;
    flush_exmem      = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    w_stall          = 1'b0;
    w_new_hz         = 1'b0;
    if (br_taken_mem) begin
      pc_redirect      = 1'b1;
      pc_redirect_addr = br_target_mem;
      flush_ifid       = 1'b1;
      flush_idex       = c_FL_IDEX;
      flush_exmem      = c_FL_EXMEM;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_hz) begin
            w_stall  = 1'b1;
            w_new_hz = 1'b1;
          end
        end
        S_STALL: w_stall = 1'b1;
        default: w_stall = 1'b0;
      endcase
      if (w_stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // FSM, remaining-bubble counter and saturating perf counters
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_RUN;
      r_remaining  <= 3'd0;
      r_stall_cnt  <= '0;
      r_hazard_cnt <= '0;
    end else begin
      if (br_taken_mem) begin
        r_state     <= S_FLUSH;
        r_remaining <= 3'd0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_hz && (LOAD_LAT > 1)) begin
              r_state     <= S_STALL;
              r_remaining <= c_REM_INIT;
            end
          end
          S_STALL: begin
            if (r_remaining <= 3'd1) begin
              r_state     <= S_RUN;
              r_remaining <= 3'd0;
            end else begin
              r_remaining <= r_remaining - 3'd1;
            end
          end
          default: begin
            r_state     <= S_RUN;
            r_remaining <= 3'd0;
          end
        endcase
      end
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_new_hz && (r_hazard_cnt != {CNT_W{1'b1}})) begin
        r_hazard_cnt <= r_hazard_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign hazard_cnt = r_hazard_cnt;

  // Forwarding selects: EX/MEM result preferred over MEM/WB, XZR never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (regwrite_mem && (rd_mem != c_ZERO) && (rd_mem == rn_ex)) begin
      fwd_a = 2'b10;
    end else if (regwrite_wb && (rd_wb != c_ZERO) && (rd_wb == rn_ex)) begin
      fwd_a = 2'b01;
    end
    if (regwrite_mem && (rd_mem != c_ZERO) && (rd_mem == rm_ex)) begin
      fwd_b = 2'b10;
    end else if (regwrite_wb && (rd_wb != c_ZERO) && (rd_wb == rm_ex)) begin
      fwd_b = 2'b01;
    end
  end

endmodule
`default_nettype wire
